// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared constants for the HD44780 text writer: the sequencing FSM state
// encoding, the bus-cycle phase encoding, the LCD command bytes, the space
// character, and small helpers that map cursor positions and init steps to
// command bytes.
// ---------------------------------------------------------------------------
package lcd_pkg;

  // Sequencing FSM states (top level)
  localparam logic [2:0] ST_POWER_WAIT = 3'd0;
  localparam logic [2:0] ST_INIT       = 3'd1;
  localparam logic [2:0] ST_IDLE       = 3'd2;
  localparam logic [2:0] ST_SET_ADDR   = 3'd3;
  localparam logic [2:0] ST_WRITE_DATA = 3'd4;

  // Bus-cycle phases (lcd_write_cycle)
  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_SETUP = 2'd1;
  localparam logic [1:0] PH_PULSE = 2'd2;
  localparam logic [1:0] PH_WAIT  = 2'd3;

  // HD44780 command bytes
  localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] CMD_LINE1        = 8'h80;
  localparam logic [7:0] CMD_LINE2        = 8'hC0;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Positions 0..15 live on line 1, 16..31 on line 2; bit 4 selects the line.
  function automatic logic [7:0] pos_to_addr(input logic [4:0] pos);
    return (pos[4] ? CMD_LINE2 : CMD_LINE1) | {4'h0, pos[3:0]};
  endfunction

  // Initialisation command issued at each step of the INIT state.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_FUNCTION_SET;
      2'd1:    cmd = CMD_DISPLAY_ON;
      2'd2:    cmd = CMD_CLEAR;
      default: cmd = CMD_ENTRY_MODE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_write_cycle.sv
// ---------------------------------------------------------------------------
// lcd_write_cycle
// Runs one HD44780 write: latches RS/DATA on start, holds E low for
// E_CYCLES, high for E_CYCLES, drops E (LCD latches on that falling edge)
// and then waits CMD_WAIT_CYCLES, or CLEAR_WAIT_CYCLES when long_wait was
// set at start. RS/DATA stay stable until the next start.
//
// Ports
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_start      one-cycle request, honoured only while idle
//   i_rs         register select for this write (0 command, 1 data)
//   i_data       byte to write
//   i_long_wait  use the clear-command settle time
//   o_lcd_e      enable strobe
//   o_lcd_rs     register select to the LCD
//   o_lcd_data   data bus to the LCD
//   o_done       one-cycle pulse when the post-write wait has elapsed
// ---------------------------------------------------------------------------
module lcd_write_cycle
  import lcd_pkg::*;
#(
  parameter int unsigned E_CYCLES          = 50,
  parameter int unsigned CMD_WAIT_CYCLES   = 5_000,
  parameter int unsigned CLEAR_WAIT_CYCLES = 200_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  input  logic       i_long_wait,
  output logic       o_lcd_e,
  output logic       o_lcd_rs,
  output logic [7:0] o_lcd_data,
  output logic       o_done
);

  localparam logic [31:0] E_LAST     = 32'(E_CYCLES - 1);
  localparam logic [31:0] CMD_LAST   = 32'(CMD_WAIT_CYCLES - 1);
  localparam logic [31:0] CLEAR_LAST = 32'(CLEAR_WAIT_CYCLES - 1);

  logic [1:0]  r_phase;
  logic [31:0] r_cnt;
  logic        r_long;
  logic        r_e;
  logic        r_rs;
  logic [7:0]  r_data;
  logic        r_done;
  logic [31:0] w_wait_last;

  assign w_wait_last = r_long ? CLEAR_LAST : CMD_LAST;

  // Phase sequencer; a single counter is reused by every timed phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_long  <= 1'b0;
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_phase)
        PH_IDLE: begin
          if (i_start) begin
            r_rs    <= i_rs;
            r_data  <= i_data;
            r_long  <= i_long_wait;
            r_cnt   <= '0;
            r_phase <= PH_SETUP;
          end
        end
        PH_SETUP: begin
          if (r_cnt == E_LAST) begin
            r_cnt   <= '0;
            r_e     <= 1'b1;
            r_phase <= PH_PULSE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        PH_PULSE: begin
          if (r_cnt == E_LAST) begin
            r_cnt   <= '0;
            r_e     <= 1'b0;
            r_phase <= PH_WAIT;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        PH_WAIT: begin
          if (r_cnt == w_wait_last) begin
            r_cnt   <= '0;
            r_phase <= PH_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  assign o_lcd_e    = r_e;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_data = r_data;
  assign o_done     = r_done;

endmodule

// File: rtl/lcd_text_writer.sv
// ---------------------------------------------------------------------------
// lcd_text_writer
// Mirrors a PS/2 keyboard line buffer onto a 2x16 HD44780 display. After a
// power-on wait and the init sequence (0x38, 0x0C, 0x01, 0x06) it watches the
// character count: a new count writes the typed character, a count one lower
// than before blanks that cell, anything else just tracks the count.
//
// Ports
//   Clock_100MHz  clock
//   Reset_n       asynchronous active-low reset
//   ASCII         character code (asynchronous)
//   Char_count    character count, legal 0..32 (asynchronous)
//   LCD_DATA      LCD data bus
//   LCD_RS        0 command, 1 character data
//   LCD_RW        always 0
//   LCD_E         enable strobe
//   Init_done     high once initialisation has finished
//   Busy          high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module lcd_text_writer
  import lcd_pkg::*;
#(
  parameter int unsigned POWER_ON_CYCLES   = 2_000_000,
  parameter int unsigned E_CYCLES          = 50,
  parameter int unsigned CMD_WAIT_CYCLES   = 5_000,
  parameter int unsigned CLEAR_WAIT_CYCLES = 200_000
) (
  input  logic       Clock_100MHz,
  input  logic       Reset_n,
  input  logic [7:0] ASCII,
  input  logic [5:0] Char_count,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic       Init_done,
  output logic       Busy
);

  localparam logic [31:0] PW_LAST = 32'(POWER_ON_CYCLES - 1);

  logic [2:0]  r_state;
  logic [31:0] r_pw_cnt;
  logic [1:0]  r_init_idx;
  logic        r_init_done;
  logic [7:0]  r_ascii_s1;
  logic [7:0]  r_ascii_s2;
  logic [5:0]  r_cnt_s1;
  logic [5:0]  r_cnt_s2;
  logic [5:0]  r_cnt_s3;
  logic [5:0]  r_last_count;
  logic [7:0]  r_char;
  logic        r_start;
  logic        r_cmd_rs;
  logic [7:0]  r_cmd_data;

  logic        w_done;
  logic        w_long_wait;
  logic        w_accept;
  logic        w_backspace;
  logic        w_typed;
  logic        w_write;
  logic [5:0]  w_prev;
  logic [4:0]  w_pos;
  logic [7:0]  w_char;

  // A count is trusted only once the synchronised value held for two cycles,
  // so a multi-bit change caught mid-transition is never acted upon.
  always_comb begin
    w_prev      = r_last_count - 6'd1;
    w_accept    = r_init_done && (r_cnt_s2 == r_cnt_s3) && (r_cnt_s2 != r_last_count);
    w_backspace = (r_cnt_s2 == w_prev) && (r_cnt_s2 <= 6'd31);
    w_typed     = (r_cnt_s2 != w_prev) && (r_cnt_s2 >= 6'd1) && (r_cnt_s2 <= 6'd32);
    w_write     = w_backspace || w_typed;
    // Count 32 lands on position 31: the low five bits wrap 0 -> 31.
    w_pos       = w_backspace ? r_cnt_s2[4:0] : (r_cnt_s2[4:0] - 5'd1);
    w_char      = w_backspace ? CHAR_SPACE : r_ascii_s2;
  end

  // Only a clear command needs the long settle time.
  assign w_long_wait = (r_cmd_data == CMD_CLEAR) && !r_cmd_rs;

  // Synchronisers and the sequencing FSM. r_start is a one-cycle request to
  // the bus-cycle engine; each bus state advances on the engine's done pulse.
  always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_POWER_WAIT;
      r_pw_cnt     <= '0;
      r_init_idx   <= 2'd0;
      r_init_done  <= 1'b0;
      r_ascii_s1   <= 8'h00;
      r_ascii_s2   <= 8'h00;
      r_cnt_s1     <= 6'd0;
      r_cnt_s2     <= 6'd0;
      r_cnt_s3     <= 6'd0;
      r_last_count <= 6'd0;
      r_char       <= 8'h00;
      r_start      <= 1'b0;
      r_cmd_rs     <= 1'b0;
      r_cmd_data   <= 8'h00;
    end else begin
      r_start    <= 1'b0;
      r_ascii_s1 <= ASCII;
      r_ascii_s2 <= r_ascii_s1;
      r_cnt_s1   <= Char_count;
      r_cnt_s2   <= r_cnt_s1;
      r_cnt_s3   <= r_cnt_s2;

      case (r_state)
        ST_POWER_WAIT: begin
          if (r_pw_cnt == PW_LAST) begin
            r_state    <= ST_INIT;
            r_init_idx <= 2'd0;
            r_cmd_rs   <= 1'b0;
            r_cmd_data <= init_cmd(2'd0);
            r_start    <= 1'b1;
          end else begin
            r_pw_cnt <= r_pw_cnt + 32'd1;
          end
        end
        ST_INIT: begin
          if (w_done) begin
            if (r_init_idx == 2'd3) begin
              r_state      <= ST_IDLE;
              r_init_done  <= 1'b1;
              // Whatever was typed during init is taken as the baseline.
              r_last_count <= r_cnt_s2;
            end else begin
              r_init_idx <= r_init_idx + 2'd1;
              r_cmd_data <= init_cmd(r_init_idx + 2'd1);
              r_start    <= 1'b1;
            end
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            r_last_count <= r_cnt_s2;
            r_char       <= w_char;
            if (w_write) begin
              r_state    <= ST_SET_ADDR;
              r_cmd_rs   <= 1'b0;
              r_cmd_data <= pos_to_addr(w_pos);
              r_start    <= 1'b1;
            end
          end
        end
        ST_SET_ADDR: begin
          if (w_done) begin
            r_state    <= ST_WRITE_DATA;
            r_cmd_rs   <= 1'b1;
            r_cmd_data <= r_char;
            r_start    <= 1'b1;
          end
        end
        ST_WRITE_DATA: begin
          if (w_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_POWER_WAIT;
      endcase
    end
  end

  lcd_write_cycle #(
    .E_CYCLES          (E_CYCLES),
    .CMD_WAIT_CYCLES   (CMD_WAIT_CYCLES),
    .CLEAR_WAIT_CYCLES (CLEAR_WAIT_CYCLES)
  ) u_write_cycle (
    .i_clk       (Clock_100MHz),
    .i_rst_n     (Reset_n),
    .i_start     (r_start),
    .i_rs        (r_cmd_rs),
    .i_data      (r_cmd_data),
    .i_long_wait (w_long_wait),
    .o_lcd_e     (LCD_E),
    .o_lcd_rs    (LCD_RS),
    .o_lcd_data  (LCD_DATA),
    .o_done      (w_done)
  );

  assign LCD_RW    = 1'b0;
  assign Init_done = r_init_done;
  assign Busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lcd_text_writer.sv
// ---------------------------------------------------------------------------
// tb_lcd_text_writer
// Bench for lcd_text_writer with short timing parameters (100/4/20/40).
// Every LCD_E falling edge is logged as {RS, DATA}; each scenario task
// compares that log, and some edge timings, against values derived from the
// display rules.
// ---------------------------------------------------------------------------
module tb_lcd_text_writer;

  logic       clk;
  logic       Reset_n;
  logic [7:0] ASCII;
  logic [5:0] Char_count;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;
  logic       Init_done;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] logQ[$];
  time        fallT[$];
  time        riseT[$];
  time        initDoneT;
  time        tRel;
  int         curCount;

  lcd_text_writer #(
    .POWER_ON_CYCLES   (100),
    .E_CYCLES          (4),
    .CMD_WAIT_CYCLES   (20),
    .CLEAR_WAIT_CYCLES (40)
  ) dut (
    .Clock_100MHz (clk),
    .Reset_n      (Reset_n),
    .ASCII        (ASCII),
    .Char_count   (Char_count),
    .LCD_DATA     (LCD_DATA),
    .LCD_RS       (LCD_RS),
    .LCD_RW       (LCD_RW),
    .LCD_E        (LCD_E),
    .Init_done    (Init_done),
    .Busy         (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The LCD latches RS/DATA on the falling edge of E.
  always @(negedge LCD_E) begin
    if (Reset_n === 1'b1) begin
      logQ.push_back({LCD_RS, LCD_DATA});
      fallT.push_back($time);
    end
  end

  always @(posedge LCD_E) riseT.push_back($time);
  always @(posedge Init_done) initDoneT = $time;

  // Expected bus traffic for one count change: 0 or 2 writes (address, char).
  function automatic int model(input int last, input int n, input logic [7:0] a,
                               output logic [8:0] addr, output logic [8:0] dat);
    int pos;
    int prev;
    prev = (last + 63) % 64;
    addr = 9'h000;
    dat  = 9'h000;
    if (n == last || n > 32) return 0;
    if (n == prev && n <= 31) begin
      pos = n;
      dat = {1'b1, 8'h20};
    end else if (n >= 1 && n != prev) begin
      pos = n - 1;
      dat = {1'b1, a};
    end else begin
      return 0;
    end
    addr = {1'b0, (pos < 16) ? 8'(128 + pos) : 8'(192 + pos - 16)};
    return 2;
  endfunction

  task automatic clear_log();
    logQ.delete();
    fallT.delete();
    riseT.delete();
  endtask

  task automatic set_count(input int n, input logic [7:0] a);
    @(negedge clk);
    Char_count = 6'(n);
    ASCII      = a;
    curCount   = n;
  endtask

  // Waits until Busy has stayed low long enough that no accepted update can
  // still be pending.
  task automatic wait_idle(output bit ok);
    int lowRun;
    ok = 1'b0;
    lowRun = 0;
    repeat (8) @(posedge clk);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!Busy) lowRun++;
      else lowRun = 0;
      if (lowRun >= 8) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_init(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (Init_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset_n    = 1'b0;
    ASCII      = 8'h00;
    Char_count = 6'd0;
    curCount   = 0;
    #23;
    checks++;
    if ({LCD_E, LCD_RS, LCD_RW} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got E/RS/RW=%b exp 000", {LCD_E, LCD_RS, LCD_RW});
    end
    checks++;
    if (LCD_DATA !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_data got %h exp 00", LCD_DATA);
    end
    checks++;
    if ({Init_done, Busy} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reset_status got Init_done/Busy=%b exp 01", {Init_done, Busy});
    end
  endtask

  // Releases reset, then checks the init bytes and their timing.
  task automatic test_init(input string tag);
    bit ok;
    logic [8:0] expInit[4];
    expInit = '{9'h038, 9'h00C, 9'h001, 9'h006};
    clear_log();
    @(negedge clk);
    Reset_n = 1'b1;
    tRel = $time;
    wait_init(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s_timeout Init_done got %b exp 1", tag, Init_done);
    end
    checks++;
    if (riseT.size() == 0 || (riseT[0] - tRel + 5) / 10 < 100) begin
      errors++;
      $display("[TB] FAIL %s_first_e got cycle %0d exp >=100", tag,
               riseT.size() == 0 ? -1 : int'((riseT[0] - tRel + 5) / 10));
    end
    checks++;
    if (logQ.size() != 4) begin
      errors++;
      $display("[TB] FAIL %s_count got %0d bus cycles exp 4", tag, logQ.size());
    end
    for (int i = 0; i < 4 && i < logQ.size(); i++) begin
      checks++;
      if (logQ[i] !== expInit[i]) begin
        errors++;
        $display("[TB] FAIL %s_byte%0d got %h exp %h", tag, i, logQ[i], expInit[i]);
      end
    end
    if (fallT.size() >= 4) begin
      checks++;
      if ((fallT[3] - fallT[2]) / 10 < 48) begin
        errors++;
        $display("[TB] FAIL %s_clear_wait got %0d cycles exp >=48", tag, (fallT[3] - fallT[2]) / 10);
      end
      checks++;
      if ((fallT[1] - fallT[0]) / 10 >= 40) begin
        errors++;
        $display("[TB] FAIL %s_cmd_wait got %0d cycles exp <40", tag, (fallT[1] - fallT[0]) / 10);
      end
      checks++;
      if ((initDoneT - fallT[3]) / 10 < 20) begin
        errors++;
        $display("[TB] FAIL %s_done_after_wait got %0d cycles exp >=20", tag, (initDoneT - fallT[3]) / 10);
      end
    end
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_busy got %b exp 0", tag, Busy);
    end
  endtask

  task automatic test_typed();
    bit ok;
    clear_log();
    set_count(1, 8'h61);
    wait_idle(ok);
    checks++;
    if (!ok || logQ.size() != 2 || logQ[0] !== 9'h080 || logQ[1] !== 9'h161) begin
      errors++;
      $display("[TB] FAIL typed got n=%0d %h %h exp 080 161", logQ.size(), logQ[0], logQ[1]);
    end
  endtask

  task automatic test_line2_backspace();
    bit ok;
    clear_log();
    set_count(17, 8'h41);
    wait_idle(ok);
    checks++;
    if (!ok || logQ.size() != 2 || logQ[0] !== 9'h0C0 || logQ[1] !== 9'h141) begin
      errors++;
      $display("[TB] FAIL line2 got n=%0d %h %h exp 0c0 141", logQ.size(), logQ[0], logQ[1]);
    end
    clear_log();
    set_count(16, 8'h41);
    wait_idle(ok);
    checks++;
    if (!ok || logQ.size() != 2 || logQ[0] !== 9'h0C0 || logQ[1] !== 9'h120) begin
      errors++;
      $display("[TB] FAIL backspace got n=%0d %h %h exp 0c0 120", logQ.size(), logQ[0], logQ[1]);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_log();
    set_count(32, 8'h7A);
    wait_idle(ok);
    set_count(1, 8'h31);
    wait_idle(ok);
    checks++;
    if (!ok || logQ.size() != 4 || logQ[0] !== 9'h0CF || logQ[1] !== 9'h17A ||
        logQ[2] !== 9'h080 || logQ[3] !== 9'h131) begin
      errors++;
      $display("[TB] FAIL wrap got n=%0d %h %h %h %h exp 0cf 17a 080 131",
               logQ.size(), logQ[0], logQ[1], logQ[2], logQ[3]);
    end
  endtask

  task automatic test_underflow();
    bit ok;
    int busyHigh;
    clear_log();
    set_count(0, 8'h55);
    wait_idle(ok);
    checks++;
    if (!ok || logQ.size() != 2 || logQ[0] !== 9'h080 || logQ[1] !== 9'h120) begin
      errors++;
      $display("[TB] FAIL bs_pos0 got n=%0d %h %h exp 080 120", logQ.size(), logQ[0], logQ[1]);
    end
    clear_log();
    set_count(63, 8'h55);
    busyHigh = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (Busy) busyHigh++;
    end
    checks++;
    if (logQ.size() != 0 || busyHigh != 0) begin
      errors++;
      $display("[TB] FAIL underflow got pulses=%0d busy_cycles=%0d exp 0 0", logQ.size(), busyHigh);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen;
    clear_log();
    set_count(1, 8'h62);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (Busy) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (5) @(negedge clk);
    set_count(5, 8'h45);
    repeat (10) @(negedge clk);
    set_count(7, 8'h47);
    checks++;
    if (!seen || Busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_busy got seen=%b Busy=%b exp 1 1", seen, Busy);
    end
    wait_idle(ok);
    checks++;
    if (!ok || logQ.size() != 4 || logQ[0] !== 9'h080 || logQ[1] !== 9'h162 ||
        logQ[2] !== 9'h086 || logQ[3] !== 9'h147) begin
      errors++;
      $display("[TB] FAIL b2b got n=%0d %h %h %h %h exp 080 162 086 147",
               logQ.size(), logQ[0], logQ[1], logQ[2], logQ[3]);
    end
  endtask

  task automatic test_random();
    bit ok;
    int n;
    int r;
    int nExp;
    logic [7:0] a;
    logic [8:0] eAddr;
    logic [8:0] eDat;
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      if (r < 3)       n = (curCount + 63) % 64;
      else if (r == 3) n = curCount;
      else if (r == 4) n = $urandom_range(33, 63);
      else             n = $urandom_range(0, 32);
      a = 8'($urandom_range(32, 126));
      nExp = model(curCount, n, a, eAddr, eDat);
      clear_log();
      set_count(n, a);
      wait_idle(ok);
      checks++;
      if (!ok || logQ.size() != nExp ||
          (nExp == 2 && (logQ[0] !== eAddr || logQ[1] !== eDat))) begin
        errors++;
        $display("[TB] FAIL rand%0d count=%0d got n=%0d %h %h exp n=%0d %h %h",
                 it, n, logQ.size(), logQ[0], logQ[1], nExp, eAddr, eDat);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_log();
    set_count((curCount + 1) % 33 == 0 ? 1 : (curCount + 1) % 33, 8'h48);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (LCD_E) begin
        seen = 1'b1;
        break;
      end
    end
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (!seen || LCD_E !== 1'b0 || Init_done !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset got seenE=%b E=%b Init_done=%b Busy=%b exp 1 0 0 1",
               seen, LCD_E, Init_done, Busy);
    end
    repeat (3) @(negedge clk);
    test_init("reinit");
    clear_log();
    repeat (30) @(negedge clk);
    checks++;
    if (logQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL reinit_baseline got %0d pulses exp 0", logQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_typed();
    test_line2_backspace();
    test_wrap();
    test_underflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_text_writer.md
LCD_TEXT_WRITER -- requirements
Module: lcd_text_writer

Interface
REQ-001 Parameter POWER_ON_CYCLES, 2_000_000, Clock_100MHz cycles waited after reset before the first command (20 ms).
REQ-002 Parameter E_CYCLES, 50, width of each LCD_E high pulse and of each LCD_E low setup phase (500 ns).
REQ-003 Parameter CMD_WAIT_CYCLES, 5_000, wait after every command or data write except clear (50 us).
REQ-004 Parameter CLEAR_WAIT_CYCLES, 200_000, wait after the clear command 0x01 (2 ms).
REQ-005 Port Clock_100MHz  input  1  sole clock; all state changes on its rising edge.
REQ-006 Port Reset_n  input  1  asynchronous, active-low reset.
REQ-007 Port ASCII  input  8  character code from the PS/2 keyboard decoder; asynchronous to Clock_100MHz.
REQ-008 Port Char_count  input  6  character count from the keyboard decoder (legal 0..32); asynchronous to Clock_100MHz.
REQ-009 Port LCD_DATA  output  8  HD44780 data bus.
REQ-010 Port LCD_RS  output  1  0 = command, 1 = character data.
REQ-011 Port LCD_RW  output  1  tied 0 (write only).
REQ-012 Port LCD_E  output  1  enable strobe; data is latched by the LCD on its falling edge.
REQ-013 Port Init_done  output  1  high once the initialisation sequence completes; stays high until reset.
REQ-014 Port Busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 ASCII and Char_count SHALL each pass through a 2-flop synchroniser; an update is accepted only when the synchronised Char_count matches on two consecutive cycles and differs from last_count.
REQ-016 The FSM SHALL use states POWER_WAIT -> INIT (commands 0x38, 0x0C, 0x01, 0x06 in that order) -> IDLE -> SET_ADDR -> WRITE_DATA -> IDLE.
REQ-017 Each bus cycle SHALL run as follows: drive LCD_RS and LCD_DATA; hold E low for E_CYCLES; hold E high for E_CYCLES; drive E low and keep RS/DATA stable; then wait CMD_WAIT_CYCLES, or CLEAR_WAIT_CYCLES after 0x01.
REQ-018 Position mapping SHALL be: position p = 0..15 -> address command 0x80|p; p = 16..31 -> 0xC0|(p-16).
REQ-019 Typed character: if new count n is in 1..32 and n != last_count-1, write at position n-1 with data ASCII.
REQ-020 Backspace: if n == last_count-1 and n is in 0..31, write at position n with data 0x20.
REQ-021 Wrap: a count going from 32 to 1 SHALL be treated as a typed character at position 0; the display is not cleared.
REQ-022 Counts 33..63 (including backspace underflow to 63) SHALL update last_count with no bus activity.
REQ-023 An unchanged count (caps lock) SHALL cause no bus activity.
REQ-024 Updates arriving while Busy SHALL NOT be queued; on return to IDLE, the current synchronised count is compared with last_count per REQ-015.
REQ-025 last_count SHALL be updated on acceptance of an update; ASCII SHALL be captured in the same cycle as that update.
REQ-026 Input changes SHALL be ignored until Init_done is high; last_count SHALL be loaded with the synchronised count when Init_done rises.

Reset
REQ-027 Reset_n low SHALL immediately force: state POWER_WAIT, LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, Init_done=0, Busy=1, last_count=0, and all counters and synchronisers cleared.
REQ-028 Reset asserted mid-cycle SHALL abort the cycle with LCD_E low; after release the full POWER_WAIT and INIT sequence is repeated.

Structure
REQ-029 Package lcd_pkg SHALL hold the state encoding, the command constants (0x38, 0x0C, 0x01, 0x06, 0x80, 0xC0) and the space code 0x20.
REQ-030 Sub-module lcd_write_cycle SHALL implement REQ-017, with a start/done handshake and a long_wait input; lcd_text_writer holds the sequencing FSM.

Verification
REQ-031 Use parameters 100/4/20/40; release reset -> first E pulse no earlier than cycle 100, then bytes 0x38, 0x0C, 0x01, 0x06 with RS=0, and Init_done rises after the final wait.
REQ-032 After init, set Char_count 0->1 with ASCII=0x61 -> bus cycles 0x80 (RS=0) then 0x61 (RS=1).
REQ-033 Set Char_count 17 with ASCII=0x41 -> bus cycles 0xC0 then 0x41; then set count 16 -> bus cycles 0xC0 then 0x20.
REQ-034 Set count 32 with ASCII=0x7A, then count 1 with ASCII=0x31 -> 0xCF/0x7A, then 0x80/0x31.
REQ-035 Set count 0 -> 63 (underflow) -> no LCD_E pulse and Busy stays low; change count twice during one write -> only the final count is written after IDLE.
REQ-036 Assert Reset_n while LCD_E is high -> LCD_E=0 and Init_done=0 immediately; after release the full init sequence repeats.
